// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded MIPS instruction fields (R-type, beq, addi,
// slti) into 32-bit words and writes them sequentially into instruction
// memory, one word per accepted valid/ready beat.
// Optional feature macro: INSTR_ENCODER_CHECK_EN
//   defined   -> kind_i 4-7 are rejected with a one-cycle err_o pulse
//   undefined -> only kind_i[1:0] is decoded; err_o is tied low
module instr_encoder #(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        kind_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W+1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_clear;
    logic                w_accept;
    logic                w_legal;
    logic [31:0]         w_word;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_ready;
    logic                r_we;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_data;

    assign w_accept = valid_i & r_ready;

`ifdef INSTR_ENCODER_CHECK_EN
    assign w_legal = ~kind_i[2];
`else
    // Only kind_i[1:0] is decoded; kind_i[2] is deliberately ignored.
    logic w_unused_kind;
    assign w_unused_kind = kind_i[2];
    assign w_legal       = 1'b1;
`endif

    // Session state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode: start opens a session from IDLE/FULL, final write fills.
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE, S_FULL: begin
                if (start_i) begin
                    w_next_state = S_RUN;
                    w_clear      = 1'b1;
                end
            end
            S_RUN: begin
                if (w_accept && w_legal && (r_ptr == PTR_LAST))
                    w_next_state = S_FULL;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Field packing; shamt is always zero and unused fields never leak in.
    always_comb begin
        w_word = '0;
        case (kind_i[1:0])
            2'd0:    w_word = {6'd0,  rs_i, rt_i, rd_i, 5'd0, funct_i};
            2'd1:    w_word = {6'd4,  rs_i, rt_i, imm_i};
            2'd2:    w_word = {6'd8,  rs_i, rt_i, imm_i};
            default: w_word = {6'd10, rs_i, rt_i, imm_i};
        endcase
    end

    // Write port, pointer and count: one register stage after acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_ready <= (w_next_state == S_RUN);
            r_we    <= 1'b0;
            if (w_clear) begin
                r_ptr   <= '0;
                r_count <= '0;
            end else if (w_accept && w_legal) begin
                r_we    <= 1'b1;
                r_addr  <= {r_ptr, 2'b00};
                r_data  <= w_word;
                r_ptr   <= r_ptr + 1'b1;
                r_count <= r_count + 1'b1;
            end
        end
    end

`ifdef INSTR_ENCODER_CHECK_EN
    logic r_err;

    // Illegal kinds are consumed without a write and flagged for one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_err <= 1'b0;
        else       r_err <= w_accept & ~w_legal;
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign ready_o    = r_ready;
    assign mem_we_o   = r_we;
    assign mem_addr_o = r_addr;
    assign mem_data_o = r_data;
    assign count_o    = r_count;
    assign full_o     = (r_state == S_FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: scoreboard of expected writes/errors filled at
// acceptance time, drained by an independent output monitor.
module tb_instr_encoder;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [2:0]        kind_i = '0;
    logic [4:0]        rs_i = '0;
    logic [4:0]        rt_i = '0;
    logic [4:0]        rd_i = '0;
    logic [5:0]        funct_i = '0;
    logic [15:0]       imm_i = '0;
    logic              mem_we_o;
    logic [ADDR_W+1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic [ADDR_W:0]   count_o;
    logic              full_o;
    logic              err_o;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .kind_i     (kind_i),
        .rs_i       (rs_i),
        .rt_i       (rt_i),
        .rd_i       (rd_i),
        .funct_i    (funct_i),
        .imm_i      (imm_i),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        int          addr;
        logic [31:0] data;
        int          count;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mptr   = 0;

`ifdef INSTR_ENCODER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from field weights rather than bit slicing.
    function automatic logic [31:0] model_word(input int kind, input int rs, input int rt,
                                               input int rd, input int funct, input int imm);
        longint w;
        int     k;
        int     op;
        k = CHECK_EN ? kind : kind % 4;
        if (k == 0) begin
            w = rs * 64'(2**21) + rt * 64'(2**16) + rd * 64'(2**11) + funct;
        end else begin
            op = (k == 1) ? 4 : (k == 2) ? 8 : 10;
            w = op * 64'(2**26) + rs * 64'(2**21) + rt * 64'(2**16) + imm;
        end
        return 32'(w);
    endfunction

    task automatic model_accept(input int kind, input int rs, input int rt, input int rd,
                                input int funct, input int imm, input int wcyc);
        exp_t e;
        bit   legal;
        legal   = !CHECK_EN || (kind < 4);
        e.cyc   = wcyc;
        e.is_err = !legal;
        e.addr  = 0;
        e.data  = '0;
        e.count = 0;
        if (legal) begin
            e.addr  = mptr * 4;
            e.data  = model_word(kind, rs, rt, rd, funct, imm);
            e.count = mptr + 1;
            mptr++;
        end
        sb.push_back(e);
    endtask

    // Presents one beat and returns at posedge+1 after its acceptance edge;
    // valid_i is left high so consecutive calls stream without gaps.
    task automatic send_beat(input int kind, input int rs, input int rt, input int rd,
                             input int funct, input int imm);
        bit accepted;
        int waited;
        kind_i  = 3'(kind);
        rs_i    = 5'(rs);
        rt_i    = 5'(rt);
        rd_i    = 5'(rd);
        funct_i = 6'(funct);
        imm_i   = 16'(imm);
        valid_i = 1'b1;
        accepted = 1'b0;
        waited   = 0;
        while (!accepted && waited < 50) begin
            @(negedge clk_i);
            if (ready_o) begin
                model_accept(kind, rs, rt, rd, funct, imm, cyc + 1);
                accepted = 1'b1;
            end
            @(posedge clk_i);
            #1;
            waited++;
        end
        if (!accepted) check("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic send_random(input bit legal_only);
        int kind;
        kind = legal_only ? $urandom_range(0, 3) : $urandom_range(0, 7);
        send_beat(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 63), $urandom_range(0, 65535));
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Monitor: every write or error pulse must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (mem_we_o || err_o) begin
                if (sb.size() == 0) begin
                    check("spurious_output", {30'd0, mem_we_o, err_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_cycle", 32'(cyc), 32'(e.cyc));
                    check("err_o", 32'(err_o), 32'(e.is_err));
                    check("mem_we_o", 32'(mem_we_o), 32'(!e.is_err));
                    if (!e.is_err) begin
                        check("mem_addr_o", 32'(mem_addr_o), 32'(e.addr));
                        check("mem_data_o", mem_data_o, e.data);
                        check("count_o@we", 32'(count_o), 32'(e.count));
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", 32'(ready_o), 0);
        check("rst_we", 32'(mem_we_o), 0);
        check("rst_addr", 32'(mem_addr_o), 0);
        check("rst_data", mem_data_o, 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_full", 32'(full_o), 0);
        check("rst_err", 32'(err_o), 0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("idle_ready", 32'(ready_o), 0);
        pulse_start();
        mptr = 0;
        check("start_ready", 32'(ready_o), 1);

        // Directed encodings, slti/beq back-to-back
        send_beat(2, 0, 8, 0, 0, 5);
        check("addi_data", mem_data_o, 32'h20080005);
        check("addi_addr", 32'(mem_addr_o), 32'h00);
        check("addi_count", 32'(count_o), 1);
        send_beat(0, 8, 9, 10, 6'h20, 0);
        check("rtype_data", mem_data_o, 32'h01095020);
        check("rtype_addr", 32'(mem_addr_o), 32'h04);
        send_beat(3, 2, 1, 0, 0, 16'hFFFF);
        check("slti_data", mem_data_o, 32'h2841FFFF);
        send_beat(1, 1, 2, 0, 0, 3);
        check("beq_data", mem_data_o, 32'h10220003);
        check("beq_addr", 32'(mem_addr_o), 32'h0C);

        // Randomized beats with occasional idle gaps
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk_i);
                #1;
            end
            send_random(1'b0);
        end

        // start_i during RUN is ignored: pointer and count keep going
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        pulse_start();
        check("run_start_ready", 32'(ready_o), 1);
        check("run_start_count", 32'(count_o), 32'(mptr));

        // Fill the memory
        while (mptr < DEPTH) send_random(1'b1);
        check("fill_last_addr", 32'(mem_addr_o), 32'h7C);
        check("fill_full", 32'(full_o), 1);
        check("fill_count", 32'(count_o), 32'(DEPTH));
        check("fill_ready", 32'(ready_o), 0);
        // A held 33rd beat must not be written (monitor flags any write)
        kind_i = 3'd2;
        imm_i  = 16'h1234;
        repeat (4) @(posedge clk_i);
        #1;
        check("held_ready", 32'(ready_o), 0);
        check("held_full", 32'(full_o), 1);
        valid_i = 1'b0;
        pulse_start();
        mptr = 0;
        check("restart_ready", 32'(ready_o), 1);
        check("restart_count", 32'(count_o), 0);
        check("restart_full", 32'(full_o), 0);

        // Kind 5: error (CHECK build) or beq write, then a legal beat
        send_beat(5, 1, 2, 7, 6'h2A, 3);
        send_beat(2, 3, 4, 0, 0, 16'h0042);
        check("post_k5_count", 32'(count_o), 32'(mptr));

        // Reset mid-stream: outputs must clear immediately
        send_random(1'b1);
        send_random(1'b1);
        #2;
        rst_i = 1'b1;
        sb.delete();
        #1;
        check("midrst_we", 32'(mem_we_o), 0);
        check("midrst_addr", 32'(mem_addr_o), 0);
        check("midrst_data", mem_data_o, 0);
        check("midrst_count", 32'(count_o), 0);
        check("midrst_ready", 32'(ready_o), 0);
        check("midrst_full", 32'(full_o), 0);
        check("midrst_err", 32'(err_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        check("post_rst_ready", 32'(ready_o), 0);
        check("post_rst_count", 32'(count_o), 0);
        check("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction loader for the single-cycle MIPS datapath. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit MIPS words. It writes the words sequentially into instruction memory, producing exactly the R-type, beq, addi and slti encodings the control decoder consumes. The core fetches the stored program after loading completes.

## Interface
- ADDR_W, 5, word-address width; memory depth is 2^ADDR_W words.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  begin a load session; honored only in IDLE or FULL.
- valid_i  in  1  instruction fields valid.
- ready_o  out  1  encoder can accept a beat; registered.
- kind_i  in  3  0=R-type, 1=beq, 2=addi, 3=slti, 4-7 illegal.
- rs_i  in  5  rs field.
- rt_i  in  5  rt field.
- rd_i  in  5  rd field; R-type only.
- funct_i  in  6  funct field; R-type only.
- imm_i  in  16  immediate or branch offset; I-type only.
- mem_we_o  out  1  instruction-memory write strobe.
- mem_addr_o  out  ADDR_W+2  byte address, equal to word index × 4.
- mem_data_o  out  32  encoded instruction.
- count_o  out  ADDR_W+1  words written this session.
- full_o  out  1  memory filled; session complete.
- err_o  out  1  one-cycle pulse on an illegal kind.

## Operation
- States: IDLE, RUN, FULL.
  - IDLE: start_i → RUN; word pointer and count_o cleared.
  - RUN: accepts beats.
  - FULL: start_i → RUN; pointer and count_o cleared.
  - start_i in RUN is ignored.
- ready_o = 1 exactly when the state is RUN. A beat is accepted when valid_i & ready_o.
- Encodings, with shamt always 0:
  - R-type: op 0, then {rs, rt, rd, 5'b0, funct}.
  - beq: op 4. addi: op 8. slti: op 10.
  - beq, addi and slti all use the I-type layout {op, rs, rt, imm}.
- Fields unused by a kind are ignored, never encoded.
- Accepted legal beat:
  - mem_data_o = encoding, mem_addr_o = pointer<<2, mem_we_o = 1 for one cycle.
  - The pointer and count_o then increment.
- Accepting the beat at pointer 2^ADDR_W−1 moves the state to FULL. count_o = 2^ADDR_W and full_o = 1 while in FULL. The pointer does not wrap into live data.
- Illegal beat (CHECK build): the beat is consumed. err_o pulses, there is no write, and the pointer is unchanged.
- Reset values: state IDLE, pointer 0, count_o 0, ready_o 0, mem_we_o 0, mem_addr_o 0, mem_data_o 0, full_o 0, err_o 0.
- Reset asserted mid-session aborts the session. Words already written stay in memory; no further write occurs.

## Timing
- Latency: beat accepted at edge N → mem_we_o/addr/data valid during cycle N+1 (one register stage).
- Sustained throughput: one word per cycle while valid_i stays high.
- mem_addr_o and mem_data_o hold their last values when mem_we_o = 0.
- ready_o falls in the cycle after the final write's acceptance edge.
  - A valid_i asserted at that point is not accepted and must be held.
- count_o updates together with the mem_we_o cycle of the corresponding write.
- FULL → RUN via start_i:
  - ready_o = 1 in the next cycle.
  - full_o = 0 and count_o = 0 in that same cycle.

## Configuration
- INSTR_ENCODER_CHECK_EN defined: kind_i 4-7 are illegal and produce the err_o behaviour above.
- INSTR_ENCODER_CHECK_EN undefined: only kind_i[1:0] is decoded, so every beat writes a word. err_o is tied to 0.

## Test plan
- Reset, start_i, then addi beat (kind 2, rs 0, rt 8, imm 5) → one cycle later: we 1, addr 0x00, data 0x20080005, count_o 1.
- R-type beat (rs 8, rt 9, rd 10, funct 0x20) following the addi → data 0x01095020 at addr 0x04.
- Back-to-back beats:
  - slti (rs 2, rt 1, imm 0xFFFF) → data 0x2841FFFF.
  - beq (rs 1, rt 2, imm 3) → data 0x10220003, at consecutive addresses with no gap cycle.
- Fill: stream 32 legal beats (ADDR_W 5) → last write at addr 0x7C, then full_o 1, count_o 32, ready_o 0. A held 33rd beat is not written. start_i → ready_o 1, count_o 0.
- kind 5 beat with CHECK_EN → err_o pulse, no write, next legal beat lands at the unchanged address. Without CHECK_EN → it is written as beq (op 4).
- Assert rst_i mid-stream → all outputs reach reset values immediately. start_i in RUN is ignored and the pointer is not cleared.
